// File: rtl/popcount_acc_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// popcount_acc_pipe
//
// Pipelined population-count accumulator. Each accepted beat is split into
// G = N_IN/12 groups. Each group is reduced by a 12-to-4 compressor. The
// group counts are summed, and the beat totals are accumulated over a
// multi-beat group that ends on in_last. One saturated total is emitted
// per group over a valid/ready handshake.
//
// Pipeline: stage 1 = per-group counts, stage 2 = beat sum,
//           stage 3 = accumulator / result register.
// The whole pipeline stalls together while a result is held unconsumed.
//
// Optional build macro: POPCOUNT_XNOR_EN
//   Adds in_weight. Stage 1 then counts ~(in_data ^ in_weight), which gives
//   an XNOR-popcount for binarised MACs.
//
// Parameters:
//   N_IN   input vector width per beat; must be a multiple of 12
//   ACC_W  accumulator/output width; must be >= clog2(N_IN+1)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (combinational)
//   in_data    bit vector to count
//   in_weight  (POPCOUNT_XNOR_EN only) weight vector, sampled with in_data
//   in_last    final beat of the current group
//   out_valid  group result valid
//   out_ready  consumer accepts result
//   out_data   saturated group popcount total
//   out_sat    total saturated at some point during this group
// -----------------------------------------------------------------------------
module popcount_acc_pipe #(
    parameter int N_IN  = 24,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
`ifdef POPCOUNT_XNOR_EN
    input  logic [N_IN-1:0]  in_weight,
`endif
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int G     = N_IN / 12;
    localparam int SUM_W = ACC_W + 1;

    if ((N_IN % 12) != 0 || N_IN < 12) begin : g_chk_n_in
        $error("popcount_acc_pipe: N_IN must be a positive multiple of 12");
    end
    if (ACC_W < CNT_W) begin : g_chk_acc_w
        $error("popcount_acc_pipe: ACC_W must be >= clog2(N_IN+1)");
    end

    // 12-to-4 compressor: four 3:2 full-adder counts, then a small adder tree.
    function automatic logic [3:0] pop12(input logic [11:0] v);
        logic [1:0] c0, c1, c2, c3;
        c0 = 2'(v[0]) + 2'(v[1])  + 2'(v[2]);
        c1 = 2'(v[3]) + 2'(v[4])  + 2'(v[5]);
        c2 = 2'(v[6]) + 2'(v[7])  + 2'(v[8]);
        c3 = 2'(v[9]) + 2'(v[10]) + 2'(v[11]);
        return (4'(c0) + 4'(c1)) + (4'(c2) + 4'(c3));
    endfunction

    // ------------------------------------------------------------------
    // Global stall: everything advances unless a result is held unread.
    // ------------------------------------------------------------------
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    logic [N_IN-1:0] cnt_vec;
    always_comb begin
`ifdef POPCOUNT_XNOR_EN
        cnt_vec = ~(in_data ^ in_weight);
`else
        cnt_vec = in_data;
`endif
    end

    // ------------------------------------------------------------------
    // Stage 1: per-group counts
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic       s1_last;
    logic [3:0] s1_cnt [G];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int unsigned g = 0; g < G; g++) begin
                s1_cnt[g] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && in_last;
            // Counts only load on real beats so in_data/in_weight are
            // don't-care on idle cycles.
            if (in_valid) begin
                for (int unsigned g = 0; g < G; g++) begin
                    s1_cnt[g] <= pop12(cnt_vec[g*12 +: 12]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: beat total (CNT_W is wide enough for N_IN, so no overflow)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] grp_sum;
    always_comb begin
        grp_sum = '0;
        for (int unsigned g = 0; g < G; g++) begin
            grp_sum = grp_sum + CNT_W'(s1_cnt[g]);
        end
    end

    logic             s2_valid;
    logic             s2_last;
    logic [CNT_W-1:0] s2_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_cnt   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_cnt <= grp_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: saturating accumulator and result register
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [SUM_W-1:0] acc_sum;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_sat;

    // One extra bit holds any carry, since acc + cnt < 2^(ACC_W+1).
    always_comb begin
        acc_sum = SUM_W'(acc) + SUM_W'(s2_cnt);
        acc_ovf = acc_sum[ACC_W];
        acc_sat = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            // en=1 means any held result is consumed this edge, so
            // out_valid simply follows whether a new result lands now.
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_data <= acc_sat;
                    out_sat  <= sticky | acc_ovf;
                    acc      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc      <= acc_sat;
                    sticky   <= sticky | acc_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_acc_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_popcount_acc_pipe
//
// Directed table of beats with hand-computed group totals (N_IN=24, ACC_W=8).
// Hand-written sequences cover latency, backpressure, reset and bubbles.
// Inputs are driven 1ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_popcount_acc_pipe;

    localparam int N_IN  = 24;
    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_sat;
`ifdef POPCOUNT_XNOR_EN
    logic [N_IN-1:0]  in_weight;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [23:0] data;
        logic        last;
        logic [7:0]  exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    popcount_acc_pipe #(
        .N_IN  (N_IN),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef POPCOUNT_XNOR_EN
        .in_weight (in_weight),
`endif
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [23:0] d, input logic l,
                                input logic [7:0] ed, input logic es);
        vec_t v;
        v.data = d; v.last = l; v.exp_data = ed; v.exp_sat = es;
        tbl.push_back(v);
    endfunction

    // Called and returns 1ns after a rising edge; leaves in_valid asserted.
    task automatic send_beat(input logic [23:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        check("beat_accepted", 32'(ok), 32'd1);
    endtask

    // Ends on the falling edge at which out_valid is seen (or budget expiry).
    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
    endtask

    // Called and returns 1ns after a rising edge.
    task automatic wait_result(input string name, input logic [7:0] ed, input logic es);
        bit seen;
        wait_valid(seen);
        check({name, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_data"}, 32'(out_data), 32'(ed));
            check({name, "_sat"},  32'(out_sat),  32'(es));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        add(24'hFFFFFF, 1'b1, 8'd24, 1'b0);
        add(24'hFFF000, 1'b0, 8'd0, 1'b0);
        add(24'h000001, 1'b0, 8'd0, 1'b0);
        add(24'h0F0F0F, 1'b1, 8'd25, 1'b0);
        add(24'h000003, 1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 10; i++) add(24'hFFFFFF, 1'b0, 8'd0, 1'b0);
        add(24'hFFFFFF, 1'b1, 8'd255, 1'b1);          // 264 clamps
        add(24'h000001, 1'b1, 8'd1, 1'b0);
        for (int i = 0; i < 10; i++) add(24'hFFFFFF, 1'b0, 8'd0, 1'b0);
        add(24'h007FFF, 1'b1, 8'd255, 1'b0);          // exactly 255, no clamp
        for (int i = 0; i < 10; i++) add(24'hFFFFFF, 1'b0, 8'd0, 1'b0);
        add(24'h00FFFF, 1'b1, 8'd255, 1'b1);          // 256 clamps on last add
        for (int i = 0; i < 11; i++) add(24'hFFFFFF, 1'b0, 8'd0, 1'b0);
        add(24'h000000, 1'b1, 8'd255, 1'b1);          // clamp earlier, sticky
        add(24'h000000, 1'b1, 8'd0, 1'b0);
        add(24'h800001, 1'b0, 8'd0, 1'b0);
        add(24'h000000, 1'b0, 8'd0, 1'b0);
        add(24'h100000, 1'b1, 8'd3, 1'b0);
        add(24'h5A5A5A, 1'b1, 8'd12, 1'b0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef POPCOUNT_XNOR_EN
        in_weight = '1;   // XNOR with all-ones counts in_data unchanged
`endif
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Latency: accepted at edge k, valid after k+2 for exactly one cycle.
        in_valid = 1'b1; in_data = 24'hFFFFFF; in_last = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_k0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_k1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_k2_valid", 32'(out_valid), 32'd1);
        check("lat_k2_data",  32'(out_data),  32'd24);
        check("lat_k2_sat",   32'(out_sat),   32'd0);
        @(negedge clk);
        check("lat_k3_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            send_beat(tbl[i].data, tbl[i].last);
            if (tbl[i].last) begin
                in_valid = 1'b0;
                wait_result($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_sat);
            end
        end
        in_valid = 1'b0;

        // Backpressure: result 7 held, group 2 queued inside, beat 4 held at input.
        out_ready = 1'b0;
        send_beat(24'h00007F, 1'b1);
        send_beat(24'h000003, 1'b1);
        in_valid = 1'b0;
        wait_valid(seen);
        check("bp_valid", 32'(seen), 32'd1);
        in_valid = 1'b1; in_data = 24'h00000F; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data",  32'(out_data),  32'd7);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_data",  32'(out_data), 32'd7);
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_q1_valid", 32'(out_valid), 32'd1);
        check("bp_q1_data",  32'(out_data),  32'd2);
        @(posedge clk);
        #1;
        wait_result("bp_q2", 8'd4, 1'b0);

        // Reset mid-group discards the partial sum.
        send_beat(24'hFFFFFF, 1'b0);
        send_beat(24'hFFFFFF, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_beat(24'h00001F, 1'b1);
        in_valid = 1'b0;
        wait_result("rst_mid", 8'd5, 1'b0);

        // Reset with a result pending clears out_valid asynchronously.
        out_ready = 1'b0;
        send_beat(24'h000003, 1'b1);
        in_valid = 1'b0;
        wait_valid(seen);
        check("rstv_pending", 32'(seen), 32'd1);
        check("rstv_pre_data", 32'(out_data), 32'd2);
        reset = 1'b1;
        #1;
        check("rstv_valid", 32'(out_valid), 32'd0);
        check("rstv_data",  32'(out_data),  32'd0);
        check("rstv_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rstv_after_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Bubbles between beats do not change the total.
        send_beat(24'hFFF000, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send_beat(24'h000001, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send_beat(24'h0F0F0F, 1'b1);
        in_valid = 1'b0;
        wait_result("bubble", 8'd25, 1'b0);

`ifdef POPCOUNT_XNOR_EN
        in_weight = 24'h0000FF;
        send_beat(24'h00FFFF, 1'b1);
        in_valid = 1'b0;
        in_weight = 24'h123456;   // ignored while idle
        wait_result("xnor", 8'd16, 1'b0);
        in_weight = '1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
